// File: rtl/l2_mem_pkg.sv
// l2_mem_pkg: shared widths, state encoding and latency limits for the downstream memory responder
package l2_mem_pkg;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 32;
  localparam int OFFSET_W = 4;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 255;
  typedef enum logic [1:0] {IDLE, READ_WAIT, RESPOND} state_t;
  function automatic int clamp_latency(int lat);
    return lat < LATENCY_MIN ? LATENCY_MIN : (lat > LATENCY_MAX ? LATENCY_MAX : lat);
  endfunction
endpackage

// File: rtl/l2_downstream_mem_responder_if.sv
// l2_downstream_mem_responder_if: snooper bus between an L2 instance and its backing memory
interface l2_downstream_mem_responder_if import l2_mem_pkg::*; ();
  logic [ADDR_W-1:0] snooper_addr;
  logic snooper_read_valid;
  logic eviction_wren;
  logic [LINE_W-1:0] evictable_cacheline;
  logic [LINE_W-1:0] updated_cacheline;
  logic cacheline_update_valid;
  logic mem_busy;
  modport master (
    output snooper_addr, snooper_read_valid, eviction_wren, evictable_cacheline,
    input updated_cacheline, cacheline_update_valid, mem_busy
  );
  modport slave (
    input snooper_addr, snooper_read_valid, eviction_wren, evictable_cacheline,
    output updated_cacheline, cacheline_update_valid, mem_busy
  );
endinterface

// File: rtl/l2_line_ram.sv
// l2_line_ram: single-clock line array, one write port and one asynchronous read port
module l2_line_ram import l2_mem_pkg::*; #(
  parameter int INDEX_W = 10
) (
  input  logic clk,
  input  logic we,
  input  logic [INDEX_W-1:0] waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic [INDEX_W-1:0] raddr,
  output logic [LINE_W-1:0] rdata
);
  logic [LINE_W-1:0] mem [2**INDEX_W];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/l2_downstream_mem_responder.sv
// l2_downstream_mem_responder: main-memory end of the L2 snooper bus; fixed-latency line reads, eviction writes
module l2_downstream_mem_responder import l2_mem_pkg::*; #(
  parameter int LATENCY = 4,
  parameter int INDEX_W = 10,
  parameter int STAT_W = 16
) (
  input  logic clk,
  input  logic reset,
  l2_downstream_mem_responder_if.slave bus,
  output logic protocol_err,
  output logic [STAT_W-1:0] read_count,
  output logic [STAT_W-1:0] evict_count
);
  localparam int LAT = clamp_latency(LATENCY);
  state_t state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic [INDEX_W-1:0] idx, req_idx;
  logic [LINE_W-1:0] ram_rd;
  logic rd, wr, accept, unused_addr_bits;
  assign idx = bus.snooper_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign unused_addr_bits = ^{bus.snooper_addr[ADDR_W-1:INDEX_W+OFFSET_W], bus.snooper_addr[OFFSET_W-1:0]};
  assign rd = bus.snooper_read_valid;
  assign wr = bus.eviction_wren;
  assign accept = rd && state == IDLE;
  assign bus.mem_busy = state != IDLE;
  l2_line_ram #(.INDEX_W(INDEX_W)) u_ram (
    .clk(clk),
    .we(wr),
    .waddr(idx),
    .wdata(bus.evictable_cacheline),
    .raddr(req_idx),
    .rdata(ram_rd)
  );
  always_comb begin
    state_nxt = state;
    wait_nxt = wait_cnt;
    state_nxt = state == IDLE ? (accept ? (LAT == 1 ? RESPOND : READ_WAIT) : IDLE)
              : state == READ_WAIT ? (wait_cnt == 8'd1 ? RESPOND : READ_WAIT)
              : IDLE;
    wait_nxt = accept ? 8'(LAT - 1) : (state == READ_WAIT ? wait_cnt - 8'd1 : wait_cnt);
  end
  // The RAM write lands at this same edge, so a colliding eviction is forwarded directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      req_idx <= '0;
      bus.updated_cacheline <= '0;
      bus.cacheline_update_valid <= 1'b0;
      protocol_err <= 1'b0;
      read_count <= '0;
      evict_count <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      bus.cacheline_update_valid <= state == RESPOND;
      if (accept) req_idx <= idx;
      if (rd && state != IDLE) protocol_err <= 1'b1;
      if (state == RESPOND) begin
        bus.updated_cacheline <= (wr && idx == req_idx) ? bus.evictable_cacheline : ram_rd;
        if (~&read_count) read_count <= read_count + 1'b1;
      end
      if (wr && ~&evict_count) evict_count <= evict_count + 1'b1;
    end
  end
endmodule
